// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, FSM state encoding and default width for the bit-serial ALU
package alu_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_DONE = 2'b10} state_t;
endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational 1-bit ALU slice (op, a, b, cin -> s, cout)
module alu_slice
  import alu_pkg::*;
(
  input  op_t  op,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic bx;
  assign bx = b ^ (op == OP_SUB);
  assign s = op == OP_AND ? a & b : op == OP_OR ? a | b : a ^ bx ^ cin;
  assign cout = (a & bx) | (a & cin) | (bx & cin);
endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl: sequences one alu_slice over WIDTH cycles, LSB first.
// Ports: clk, rst (sync, active high), start/op/a/b request an operation;
// busy while bits are processed, done one-cycle pulse, result and c_out held until next start.
module bit_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state;
  op_t op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0] cnt;
  logic carry, s, co;
  // operands shift right each bit so the slice always sees bit 0
  alu_slice u_slice (.op(op_q), .a(a_q[0]), .b(b_q[0]), .cin(carry), .s(s), .cout(co));
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_AND;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          op_q  <= op_t'(op);
          cnt   <= '0;
          carry <= op_t'(op) == OP_SUB;
          busy  <= 1'b1;
          state <= S_RUN;
        end
        S_RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          result <= {s, result[WIDTH-1:1]};
          carry  <= co;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            c_out <= (op_q == OP_ADD || op_q == OP_SUB) && co;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// tb_bit_serial_alu_ctrl: directed self-checking bench for bit_serial_alu_ctrl at WIDTH=8
module tb_bit_serial_alu_ctrl;
  logic clk = 1'b0;
  logic rst, start;
  logic [1:0] op;
  logic [7:0] a, b, result;
  logic busy, done, c_out;
  int n_cmp = 0;
  int n_err = 0;
  int n_done;

  bit_serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // start at edge E0, scramble inputs mid-run, expect done exactly at E8
  task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic ec);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    chk({tag, "_busy0"}, busy, 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk({tag, "_early_done"}, done, 0);
      if (i == 7) chk({tag, "_busy7"}, busy, 1);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_result"}, result, er);
    chk({tag, "_c_out"}, c_out, ec);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_c_out", c_out, 0);
    rst = 1'b0;

    do_op("add_ff_01", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1);
    do_op("sub_05_07", 2'b11, 8'h05, 8'h07, 8'hFE, 1'b0);
    do_op("sub_07_05", 2'b11, 8'h07, 8'h05, 8'h02, 1'b1);
    do_op("and_f0_3c", 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0);
    do_op("or_f0_3c",  2'b01, 8'hF0, 8'h3C, 8'hFC, 1'b0);
    do_op("add_80_80", 2'b10, 8'h80, 8'h80, 8'h00, 1'b1);
    do_op("sub_33_33", 2'b11, 8'h33, 8'h33, 8'h00, 1'b1);
    do_op("add_5a_21", 2'b10, 8'h5A, 8'h21, 8'h7B, 1'b0);

    // start in the DONE cycle must be ignored; result holds
    start = 1'b1; op = 2'b10; a = 8'h01; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_ignored_busy", busy, 0);
    chk("b2b_ignored_done", done, 0);
    chk("b2b_hold_result", result, 8'h7B);
    chk("b2b_hold_c_out", c_out, 0);
    @(negedge clk);
    chk("b2b_still_idle", busy, 0);
    // start the cycle right after DONE is accepted
    do_op("b2b_and", 2'b00, 8'h0F, 8'hFF, 8'h0F, 1'b0);
    do_op("b2b_next", 2'b01, 8'h01, 8'h02, 8'h03, 1'b0);

    // start held high: one done per 10 cycles, results follow latched operands
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 8'h10; b = 8'h20;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin op = 2'b11; a = 8'h07; b = 8'h05; end
      if (k == 10) begin op = 2'b01; a = 8'hF0; b = 8'h3C; end
      if (k == 20) begin op = 2'b00; a = 8'h00; b = 8'h00; end
      if (k == 29) start = 1'b0;
      if (k % 10 == 8 || done) chk("stream_done_slot", done, k % 10 == 8);
      if (done) begin
        n_done++;
        if (k == 8)  begin chk("stream_r0", result, 8'h30); chk("stream_c0", c_out, 0); end
        if (k == 18) begin chk("stream_r1", result, 8'h02); chk("stream_c1", c_out, 1); end
        if (k == 28) begin chk("stream_r2", result, 8'hFC); chk("stream_c2", c_out, 0); end
      end
    end
    chk("stream_done_count", n_done, 3);
    repeat (2) @(negedge clk);
    chk("stream_stopped", busy, 0);

    // reset while bit 4 is processed aborts the operation
    start = 1'b1; op = 2'b10; a = 8'hAA; b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_c_out", c_out, 0);
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    do_op("add_12_34", 2'b10, 8'h12, 8'h34, 8'h46, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bit_serial_alu_ctrl.md
BIT_SERIAL_ALU_CTRL -- requirements
Module: bit_serial_alu_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (all state updates on the rising edge) and rst.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal range 2..32).
REQ-003 Port clk SHALL be: input, 1 bit, system clock.
REQ-004 Port rst SHALL be: input, 1 bit, synchronous active-high reset.
REQ-005 Port start SHALL be: input, 1 bit, request a new operation.
REQ-006 Port op SHALL be: input, 2 bits, operation select (00 AND, 01 OR, 10 ADD, 11 SUB).
REQ-007 Port a SHALL be: input, WIDTH bits, operand A.
REQ-008 Port b SHALL be: input, WIDTH bits, operand B.
REQ-009 Port busy SHALL be: output, 1 bit, high while bits are being processed.
REQ-010 Port done SHALL be: output, 1 bit, one-cycle completion pulse.
REQ-011 Port result SHALL be: output, WIDTH bits, operation result.
REQ-012 Port c_out SHALL be: output, 1 bit, carry out of the MSB.

Function
REQ-013 The block SHALL sequence a single 1-bit ALU slice over WIDTH cycles, LSB first, keeping the inter-bit carry in a flip-flop.
REQ-014 The FSM SHALL have three states with these transitions: IDLE -> RUN on start; RUN -> DONE after WIDTH bit cycles; DONE -> IDLE unconditionally.
REQ-015 At the edge where start is sampled high in IDLE, the block SHALL latch a, b and op, clear the bit counter, and set carry to 1 for SUB and to 0 otherwise.
REQ-016 On each RUN edge, the block SHALL apply bit cnt of A and B to the slice, shift the slice output into the result shift register from the MSB side, load carry from the slice c_out, and increment cnt.
REQ-017 The slice SHALL compute: AND = a&b; OR = a|b; ADD = a^b^cin; SUB = ADD with b inverted; cout = majority(a, b', cin), where b' is b inverted for SUB and b otherwise.
REQ-018 Timing SHALL be: start sampled at edge E0; busy high from E0 to E_WIDTH; done high for exactly one cycle, from E_WIDTH to E_WIDTH+1.
REQ-019 result SHALL hold its final value from E_WIDTH until the next accepted start.
REQ-020 c_out SHALL be the final carry for ADD, the no-borrow flag (1 when A >= B unsigned) for SUB, and 0 for AND/OR; it SHALL hold with result.
REQ-021 The block SHALL ignore start while in RUN or DONE, with no queuing; input changes during RUN SHALL NOT affect the operation in progress.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH, with the wrap-around reported only through c_out.

Reset
REQ-023 rst SHALL take priority over start and over any FSM activity.
REQ-024 After reset: state IDLE; busy=0; done=0; result=0; c_out=0; carry=0; cnt=0.
REQ-025 Reset asserted during RUN or DONE SHALL abort the operation, and no done pulse SHALL follow.

Structure
REQ-026 Shared package alu_pkg SHALL hold the op encodings (OP_AND, OP_OR, OP_ADD, OP_SUB), the FSM state encoding and the default WIDTH.
REQ-027 The combinational 1-bit slice with carry-in SHALL be a separate sub-module named alu_slice, instantiated once.
REQ-028 The counter width SHALL be clog2(WIDTH+1).

Verification (WIDTH=8)
REQ-029 ADD A=0xFF, B=0x01 -> result=0x00, c_out=1, done exactly 8 cycles after the start edge.
REQ-030 SUB A=0x05, B=0x07 -> result=0xFE, c_out=0; SUB A=0x07, B=0x05 -> result=0x02, c_out=1.
REQ-031 AND A=0xF0, B=0x3C -> result=0x30; OR with the same operands -> result=0xFC; c_out=0 for both.
REQ-032 start held high continuously, with op or operands changed mid-RUN -> exactly one done per 10-cycle period, and results match the operands latched at each accepted start.
REQ-033 rst pulsed at bit 4 of an ADD -> busy=0 next cycle, no done pulse, result=0; a new ADD 0x12+0x34 then yields 0x46.
REQ-034 Back-to-back: start asserted in the DONE cycle is ignored; start asserted the cycle after DONE is accepted.
